// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix codes, key-event layout and frame FSM encoding.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT = 8'hE0;
  localparam logic [7:0]  PS2_BRK = 8'hF0;

  localparam int unsigned EVT_W        = 10;
  localparam int unsigned EVT_CODE_LSB = 0;
  localparam int unsigned EVT_BRK_BIT  = 8;
  localparam int unsigned EVT_EXT_BIT  = 9;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StPar,
    StStop
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Odd parity over data+parity and a high stop bit.
  function automatic logic frame_ok(logic [7:0] data, logic par, logic stop);
    return (^{data, par}) & stop;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and a drop strobe.
module ps2_evt_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             vacio_o,
  output logic             lleno_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count;
  logic             do_push, do_pop;

  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    vacio_o   = (count == '0);
    lleno_o   = (count == PW'(DEPTH));
    do_pop    = rd_en_i & ~vacio_o;
    // A pop in the same cycle frees the slot the push lands in.
    do_push   = wr_en_i & (~lleno_o | do_pop);
    drop_o    = wr_en_i & lleno_o & ~do_pop;
    wr_ptr_d  = wr_ptr_q + PW'(do_push);
    rd_ptr_d  = rd_ptr_q + PW'(do_pop);
    rd_data_o = vacio_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ps2_teclado_fifo.sv
// PS/2 keyboard front-end: filtered clock, frame FSM with watchdog, E0/F0 prefix decoder
// and a buffered event queue for the consumer.
module ps2_teclado_fifo import ps2_pkg::*; #(
  parameter int unsigned FILTRO_BITS  = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned TIMEOUT_CYC  = 200000,
  parameter bit          REPORT_BREAK = 1'b1
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] dato,
  output logic       extendido,
  output logic       liberado,
  output logic       vacio,
  output logic       lleno,
  output logic       desborde,
  output logic       error_paridad,
  output logic       err_trama
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

  // Synchronisers and glitch filter
  logic [1:0]             c_sync_q, d_sync_q;
  logic                   ps2c_s, ps2d_s;
  logic [FILTRO_BITS-1:0] filt_sh_q;
  logic                   filt_q, filt_d;
  logic                   fall;

  assign ps2c_s = c_sync_q[1];
  assign ps2d_s = d_sync_q[1];

  always_comb begin
    filt_d = filt_q;
    if (&filt_sh_q) begin
      filt_d = 1'b1;
    end else if (~|filt_sh_q) begin
      filt_d = 1'b0;
    end
  end

  assign fall = filt_q & ~filt_d;

  always_ff @(posedge reloj) begin
    if (!reset) begin
      c_sync_q  <= 2'b11;
      d_sync_q  <= 2'b11;
      filt_sh_q <= '1;
      filt_q    <= 1'b1;
    end else begin
      c_sync_q  <= {c_sync_q[0], ps2c};
      d_sync_q  <= {d_sync_q[0], ps2d};
      filt_sh_q <= {filt_sh_q[FILTRO_BITS-2:0], ps2c_s};
      filt_q    <= filt_d;
    end
  end

  // Frame FSM and watchdog
  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          frame_vld_q, frame_vld_d;
  logic          frame_ok_q, frame_ok_d;
  logic          timeout;
  logic          err_trama_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    par_d       = par_q;
    frame_vld_d = 1'b0;
    frame_ok_d  = 1'b0;
    timeout     = 1'b0;
    to_d        = (state_q == StIdle || fall) ? '0 : to_q + TW'(1);
    if (state_q != StIdle && !fall && to_q == TO_MAX) begin
      timeout = 1'b1;
      state_d = StIdle;
      to_d    = '0;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!ps2d_s) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          data_d    = {ps2d_s, data_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StPar;
          end
        end
        StPar: begin
          par_d   = ps2d_s;
          state_d = StStop;
        end
        StStop: begin
          frame_vld_d = 1'b1;
          frame_ok_d  = frame_ok(data_q, par_q, ps2d_s);
          state_d     = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge reloj) begin
    if (!reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      to_q        <= '0;
      frame_vld_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      err_trama_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      par_q       <= par_d;
      to_q        <= to_d;
      frame_vld_q <= frame_vld_d;
      frame_ok_q  <= frame_ok_d;
      err_trama_q <= timeout;
    end
  end

  // Prefix decoder
  logic     ext_q, ext_d;
  logic     brk_q, brk_d;
  logic     push_q, push_d;
  ps2_evt_t evt_q, evt_d;
  logic     par_err_set;

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    push_d      = 1'b0;
    evt_d       = evt_q;
    par_err_set = 1'b0;
    if (err_trama_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (frame_vld_q) begin
      if (!frame_ok_q) begin
        par_err_set = 1'b1;
        ext_d       = 1'b0;
        brk_d       = 1'b0;
      end else if (data_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (data_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        evt_d.ext  = ext_q;
        evt_d.brk  = brk_q;
        evt_d.code = data_q;
        push_d     = !(brk_q && (REPORT_BREAK == 1'b0));
        ext_d      = 1'b0;
        brk_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge reloj) begin
    if (!reset) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      push_q <= 1'b0;
      evt_q  <= '0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      push_q <= push_d;
      evt_q  <= evt_d;
    end
  end

  // Event queue and sticky flags
  logic [EVT_W-1:0] head;
  logic             drop;
  logic             err_par_q, desborde_q;

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (reloj),
    .rst_ni    (reset),
    .wr_en_i   (push_q),
    .wr_data_i (evt_q),
    .rd_en_i   (rd_en),
    .rd_data_o (head),
    .vacio_o   (vacio),
    .lleno_o   (lleno),
    .drop_o    (drop)
  );

  // A set in the same cycle as clr_err wins.
  always_ff @(posedge reloj) begin
    if (!reset) begin
      err_par_q  <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      if (par_err_set) begin
        err_par_q <= 1'b1;
      end else if (clr_err) begin
        err_par_q <= 1'b0;
      end
      if (drop) begin
        desborde_q <= 1'b1;
      end else if (clr_err) begin
        desborde_q <= 1'b0;
      end
    end
  end

  assign dato          = head[EVT_CODE_LSB +: 8];
  assign extendido     = head[EVT_EXT_BIT];
  assign liberado      = head[EVT_BRK_BIT];
  assign desborde      = desborde_q;
  assign error_paridad = err_par_q;
  assign err_trama     = err_trama_q;

endmodule

// File: tb/tb_ps2_teclado_fifo.sv
// Scoreboard bench: directed PS/2 frames into two instances (break reporting on and off).
`timescale 1ns/1ps
module tb_ps2_teclado_fifo;

  localparam int unsigned FILT  = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TOUT  = 300;
  localparam int HALF = 20;
  localparam int GAP  = 30;

  logic reloj = 1'b0;
  logic reset, ps2c, ps2d, clr_err;
  logic rd_man = 1'b0, rd_mon = 1'b0, rd_nb = 1'b0;
  logic rd_en;
  assign rd_en = rd_man | rd_mon;

  logic [7:0] dato, dato_nb;
  logic extendido, liberado, vacio, lleno, desborde, error_paridad, err_trama;
  logic extendido_nb, liberado_nb, vacio_nb, lleno_nb, desborde_nb, error_paridad_nb;
  logic err_trama_nb;

  ps2_teclado_fifo #(
    .FILTRO_BITS (FILT), .DEPTH (DEPTH), .TIMEOUT_CYC (TOUT), .REPORT_BREAK (1'b1)
  ) dut (
    .reloj (reloj), .reset (reset), .ps2c (ps2c), .ps2d (ps2d), .rd_en (rd_en),
    .clr_err (clr_err), .dato (dato), .extendido (extendido), .liberado (liberado),
    .vacio (vacio), .lleno (lleno), .desborde (desborde), .error_paridad (error_paridad),
    .err_trama (err_trama)
  );

  ps2_teclado_fifo #(
    .FILTRO_BITS (FILT), .DEPTH (DEPTH), .TIMEOUT_CYC (TOUT), .REPORT_BREAK (1'b0)
  ) dut_nb (
    .reloj (reloj), .reset (reset), .ps2c (ps2c), .ps2d (ps2d), .rd_en (rd_nb),
    .clr_err (clr_err), .dato (dato_nb), .extendido (extendido_nb),
    .liberado (liberado_nb), .vacio (vacio_nb), .lleno (lleno_nb),
    .desborde (desborde_nb), .error_paridad (error_paridad_nb), .err_trama (err_trama_nb)
  );

  always #5 reloj = ~reloj;

  logic [9:0] exp_q[$];
  logic [9:0] exp_nb[$];
  int n_cmp = 0, n_bad = 0;
  int cyc_cnt = 0, lat_base = -1, trama_cnt = 0;
  bit auto_pop = 1'b0, pop_at_write = 1'b0;

  always @(posedge reloj) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ev(input bit e, input bit b, input logic [7:0] c);
    return {e, b, c};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge reloj);
    #1;
  endtask

  // Device-to-host frame: start, 8 data LSB first, odd parity, stop; nbits<11 truncates it.
  task automatic send_frame(input logic [7:0] code, input bit flip_par, input bit bad_stop,
                            input int nbits, input bit glitch, input bit mark);
    logic [10:0] fb;
    fb = {~bad_stop, (~^code) ^ flip_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge reloj); #1;
      ps2d = fb[i];
      if (glitch && i == 4) begin
        repeat (6) @(posedge reloj);
        #1 ps2c = 1'b0;
        repeat (3) @(posedge reloj);
        #1 ps2c = 1'b1;
      end
      repeat (HALF) @(posedge reloj);
      #1 ps2c = 1'b0;
      if (mark && i == 10) lat_base = cyc_cnt;
      repeat (HALF) @(posedge reloj);
      #1 ps2c = 1'b1;
    end
    repeat (GAP) @(posedge reloj);
    #1 ps2d = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while ((exp_q.size() != 0 || exp_nb.size() != 0) && i < 500) begin
      @(posedge reloj);
      i++;
    end
    #1;
    check(name, exp_q.size() + exp_nb.size(), 0);
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_vacio"}, vacio, 1'b1);
    check({name, "_lleno"}, lleno, 1'b0);
    check({name, "_desborde"}, desborde, 1'b0);
    check({name, "_err_par"}, error_paridad, 1'b0);
    check({name, "_err_trama"}, err_trama, 1'b0);
    check({name, "_head"}, {extendido, liberado, dato}, 10'h0);
    check({name, "_nb"}, {vacio_nb, lleno_nb, desborde_nb, error_paridad_nb, err_trama_nb,
                          extendido_nb, liberado_nb, dato_nb}, 15'h4000);
  endtask

  // Monitor: pops and compares whenever the instance presents an event.
  initial begin
    forever begin
      @(posedge reloj); #1;
      rd_mon = 1'b0;
      if (auto_pop && reset && !vacio) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_event: got 0x%0h, expected none", {extendido, liberado, dato});
        end else begin
          check("event", {extendido, liberado, dato}, exp_q.pop_front());
        end
        rd_mon = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge reloj); #1;
      rd_nb = 1'b0;
      if (reset && !vacio_nb) begin
        if (exp_nb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_event_nb: got 0x%0h, expected none",
                   {extendido_nb, liberado_nb, dato_nb});
        end else begin
          check("event_nb", {extendido_nb, liberado_nb, dato_nb}, exp_nb.pop_front());
        end
        rd_nb = 1'b1;
      end
    end
  end

  // Stop-bit fall driven in cycle c: filter fires 9 edges later, write lands on edge c+13.
  initial begin
    forever begin
      @(posedge reloj); #1;
      if (lat_base >= 0) begin
        if (cyc_cnt == lat_base + 12) begin
          if (pop_at_write) begin
            check("full_before_pushpop", lleno, 1'b1);
            check("head_at_pushpop", {extendido, liberado, dato}, exp_q.pop_front());
            rd_man = 1'b1;
          end else begin
            check("vacio_before_write", vacio, 1'b1);
          end
        end else if (cyc_cnt == lat_base + 13) begin
          if (pop_at_write) begin
            rd_man = 1'b0;
            check("lleno_after_pushpop", lleno, 1'b1);
          end else begin
            check("vacio_after_write", vacio, 1'b0);
          end
          lat_base = -1;
          pop_at_write = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge reloj); #1;
      if (err_trama === 1'b1) trama_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int t0;
    int i;
    reset = 1'b0; ps2c = 1'b1; ps2d = 1'b1; clr_err = 1'b0;
    tick(5);
    check_reset_outs("por");
    reset = 1'b1; auto_pop = 1'b1;
    tick(20);

    // Plain make code with latency check
    exp_q.push_back(ev(0, 0, 8'h1C)); exp_nb.push_back(ev(0, 0, 8'h1C));
    send_frame(8'h1C, 0, 0, 11, 0, 1);
    wait_drain("t1_drain");
    tick(2);
    check("t1_vacio", vacio, 1'b1);

    // Break: reported on dut, discarded on dut_nb
    exp_q.push_back(ev(0, 1, 8'h1C));
    send_frame(8'hF0, 0, 0, 11, 0, 0);
    send_frame(8'h1C, 0, 0, 11, 0, 0);
    wait_drain("t2_drain");
    check("t2_nb_vacio", vacio_nb, 1'b1);

    // Extended break
    exp_q.push_back(ev(1, 1, 8'h75));
    send_frame(8'hE0, 0, 0, 11, 0, 0);
    send_frame(8'hF0, 0, 0, 11, 0, 0);
    send_frame(8'h75, 0, 0, 11, 0, 0);
    wait_drain("t3_drain");

    // Parity error, bad stop clears the F0, then a clean make
    send_frame(8'h1C, 1, 0, 11, 0, 0);
    tick(2);
    check("t4_err_par_set", error_paridad, 1'b1);
    check("t4_no_event", vacio, 1'b1);
    send_frame(8'hF0, 0, 1, 11, 0, 0);
    exp_q.push_back(ev(0, 0, 8'h29)); exp_nb.push_back(ev(0, 0, 8'h29));
    send_frame(8'h29, 0, 0, 11, 0, 0);
    wait_drain("t4_drain");
    check("t4_err_par_sticky", error_paridad, 1'b1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t4_err_par_clr", error_paridad, 1'b0);

    // Fill, overflow, push+pop at full
    auto_pop = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(ev(0, 0, 8'(k))); exp_nb.push_back(ev(0, 0, 8'(k)));
      send_frame(8'(k), 0, 0, 11, 0, 0);
    end
    check("t5_lleno", lleno, 1'b1);
    check("t5_no_desborde", desborde, 1'b0);
    exp_nb.push_back(ev(0, 0, 8'h09));
    send_frame(8'h09, 0, 0, 11, 0, 0);
    check("t5_desborde", desborde, 1'b1);
    check("t5_lleno_drop", lleno, 1'b1);
    exp_q.push_back(ev(0, 0, 8'h0A)); exp_nb.push_back(ev(0, 0, 8'h0A));
    pop_at_write = 1'b1;
    send_frame(8'h0A, 0, 0, 11, 0, 1);
    check("t5_lleno_pushpop", lleno, 1'b1);
    auto_pop = 1'b1;
    wait_drain("t5_drain");
    tick(2);
    check("t5_vacio", {vacio, lleno}, 2'b10);
    check("t5_desborde_sticky", desborde, 1'b1);

    // Watchdog on a truncated frame, then a glitched but valid frame
    t0 = trama_cnt;
    send_frame(8'h55, 0, 0, 5, 0, 0);
    i = 0;
    while (trama_cnt == t0 && i < 4 * TOUT) begin
      tick(1);
      i++;
    end
    tick(5);
    check("t6_err_trama_pulse", trama_cnt, t0 + 1);
    check("t6_no_event", vacio, 1'b1);
    exp_q.push_back(ev(0, 0, 8'h29)); exp_nb.push_back(ev(0, 0, 8'h29));
    send_frame(8'h29, 0, 0, 11, 1, 0);
    wait_drain("t6_glitch_drain");
    check("t6_glitch_no_err", error_paridad, 1'b0);

    // Reset in the middle of a frame with an event buffered
    auto_pop = 1'b0;
    exp_nb.push_back(ev(0, 0, 8'h33));
    send_frame(8'h33, 0, 0, 11, 0, 0);
    check("t7_head_before_reset", {vacio, dato}, 9'h033);
    wait_drain("t7_nb_drain");
    send_frame(8'h44, 0, 0, 5, 0, 0);
    reset = 1'b0;
    tick(1);
    check_reset_outs("mid_reset");
    exp_q.delete();
    tick(3);
    reset = 1'b1; auto_pop = 1'b1;
    tick(20);
    exp_q.push_back(ev(0, 0, 8'h1C)); exp_nb.push_back(ev(0, 0, 8'h1C));
    send_frame(8'h1C, 0, 0, 11, 0, 0);
    wait_drain("t7_recover_drain");
    check("total_err_trama", trama_cnt, t0 + 1);

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
